// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one fixed-latency memory port shared by fetch (I) and load/store (D).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; the default build gives D fixed priority.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              side_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              any_req;
  logic              grant;
  logic              pick_d;
  logic              last_cyc;

  assign any_req  = i_req | d_req;
  assign grant    = (state_q == IDLE) & any_req;
  assign last_cyc = (state_q == BUSY) & (cnt_q == '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_grant: 1 = D was granted most recently
  logic last_grant_q;

  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) begin
      pick_d = ~last_grant_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b0;
    end else if (grant) begin
      last_grant_q <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      side_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      cnt_q   <= CNT_INIT;
      side_q  <= pick_d;
      we_q    <= pick_d & d_we;
      addr_q  <= pick_d ? d_addr : i_addr;
      wdata_q <= d_wdata;
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Read data is captured only for loads/fetches; stores leave d_rdata alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (last_cyc && !we_q) begin
      if (side_q) begin
        d_rdata_q <= mem_rdata;
      end else begin
        i_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = last_cyc & we_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign busy      = (state_q != IDLE);

  assign i_valid = (state_q == RESP) & ~side_q;
  assign d_valid = (state_q == RESP) & side_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  // Stalls are forced low while in reset so every output reads 0
  assign i_stall = reset_n & i_req & ~i_valid;
  assign d_stall = reset_n & d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a transaction-level reference model.
// Covers directed cases, randomized traffic and a MEM_LATENCY=1 instance.
module tb_mem_port_arbiter;

  localparam int L = 4;

  typedef struct {
    bit          side_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_valid, d_valid, i_stall, d_stall;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        i_req1;
  logic [31:0] i_addr1;
  logic        i_valid1, i_stall1, d_valid1, d_stall1;
  logic [31:0] i_rdata1, d_rdata1;
  logic        mem_req1, mem_we1, busy1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int i_done = 0, d_done = 0;
  int i_seen = 0, d_seen = 0;

  exp_t exp_q[$];
  int   free_at = 0;
  int   gnt_cyc = -100;
  bit   last_d = 1'b0;
  logic [31:0] exp_i = '0, exp_d = '0;

  logic [31:0] mem [256];
  bit          mem_wr [256];
  logic [31:0] ref_mem [256];
  bit          ref_wr [256];
  logic [7:0]  ridx;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return (i == 8'd4) ? 32'h00500093 : {i, ~i, i ^ 8'h3C, 8'h5A};
  endfunction

  function automatic logic [31:0] raddr();
    return 32'h100 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  assign ridx = mem_addr[9:2];
  assign mem_rdata = mem_wr[ridx] ? mem[ridx] : init_word(ridx);
  assign mem_rdata1 = ~mem_addr1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[ridx]    <= mem_wdata;
      mem_wr[ridx] <= 1'b1;
    end
  end

  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_valid(i_valid1),
    .i_rdata(i_rdata1), .i_stall(i_stall1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_valid(d_valid1), .d_rdata(d_rdata1), .d_stall(d_stall1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Reference model: one access at a time, each occupying L+2 cycles
  always @(negedge clk) begin
    exp_t e;
    bit pick;
    logic [7:0] k;
    if (!reset_n) begin
      exp_q.delete();
      free_at = 0;
      gnt_cyc = -100;
      last_d  = 1'b0;
    end else if (cyc >= free_at && (i_req || d_req)) begin
      pick = d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (i_req && d_req) pick = !last_d;
      last_d = pick;
`endif
      e.side_d = pick;
      e.we     = pick && d_we;
      e.addr   = pick ? d_addr : i_addr;
      e.wdata  = d_wdata;
      k        = e.addr[9:2];
      e.rdata  = ref_wr[k] ? ref_mem[k] : init_word(k);
      e.due    = cyc + L + 1;
      exp_q.push_back(e);
      gnt_cyc = cyc;
      free_at = cyc + L + 2;
    end
  end

  // Monitor: pops on completions and checks the per-cycle outputs
  always @(negedge clk) begin
    exp_t e;
    bit ok, has, ebusy, emreq, ewe;
    logic [7:0] k;
    if (!reset_n) begin
      exp_i = '0;
      exp_d = '0;
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid: side_d=%0b addr=%h due %0d, now %0d",
                 e.side_d, e.addr, e.due, cyc);
      end
      if (i_valid || d_valid) begin
        checks++;
        if (exp_q.size() == 0 || (i_valid && d_valid)) begin
          errors++;
          $display("FAIL valid: unexpected i_valid=%0b d_valid=%0b cycle %0d",
                   i_valid, d_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          k = e.addr[9:2];
          ok = (d_valid == e.side_d) && (cyc == e.due);
          if (!e.side_d) ok = ok && (i_rdata == e.rdata);
          if (e.side_d && !e.we) ok = ok && (d_rdata == e.rdata);
          if (e.we) ok = ok && mem_wr[k] && (mem[k] == e.wdata) && (d_rdata == exp_d);
          if (!ok) begin
            errors++;
            $display("FAIL completion: got d=%0b cyc=%0d i_rd=%h d_rd=%h mem=%h want d=%0b cyc=%0d rd=%h wd=%h",
                     d_valid, cyc, i_rdata, d_rdata, mem[k], e.side_d, e.due, e.rdata, e.wdata);
          end
          if (e.we) begin
            ref_mem[k] = e.wdata;
            ref_wr[k]  = 1'b1;
          end else if (e.side_d) begin
            exp_d = e.rdata;
          end else begin
            exp_i = e.rdata;
          end
        end
        if (i_valid) i_done++;
        if (d_valid) d_done++;
      end
      has   = exp_q.size() != 0;
      ebusy = (cyc > gnt_cyc) && (cyc < free_at);
      emreq = (cyc > gnt_cyc) && (cyc <= gnt_cyc + L);
      ewe   = emreq && has && exp_q[0].we && (cyc == gnt_cyc + L);
      ok = (busy == ebusy) && (mem_req == emreq) && (mem_we == ewe) &&
           (i_stall == (i_req && !i_valid)) &&
           (d_stall == (d_req && !d_valid)) &&
           (i_rdata == exp_i) && (d_rdata == exp_d);
      if (emreq && has) ok = ok && (mem_addr == exp_q[0].addr);
      if (ewe) ok = ok && (mem_wdata == exp_q[0].wdata);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cycle %0d: busy=%0b/%0b mem_req=%0b/%0b mem_we=%0b/%0b ist=%0b dst=%0b i_rd=%h/%h d_rd=%h/%h addr=%h",
                 cyc, busy, ebusy, mem_req, emreq, mem_we, ewe, i_stall,
                 d_stall, i_rdata, exp_i, d_rdata, exp_d, mem_addr);
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((i_req || d_req) && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (i_done != i_seen) begin i_seen = i_done; i_req = 1'b0; end
      if (d_done != d_seen) begin d_seen = d_done; d_req = 1'b0; end
    end
    checks++;
    if (i_req || d_req) begin
      errors++;
      $display("FAIL timeout: i_req=%0b d_req=%0b still pending after %0d cycles",
               i_req, d_req, budget);
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0;
    bit eb, ev;
    reset_n = 1'b1;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req1 = 0; i_addr1 = 32'h44;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i_valid, d_valid, mem_req, mem_we, busy, i_stall, d_stall} != 7'b0 ||
        mem_addr != 0 || mem_wdata != 0 || i_rdata != 0 || d_rdata != 0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (busy=%0b mem_req=%0b)",
               busy, mem_req);
    end
    reset_n = 1'b1;

    // Fetch from 0x10
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h10;
    wait_done(30);
    checks++;
    if (i_rdata != 32'h00500093) begin
      errors++;
      $display("FAIL fetch_0x10: i_rdata=%h want 00500093", i_rdata);
    end

    // Store then load at 0x100
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    wait_done(30);
    d_req = 1; d_we = 0;
    wait_done(30);
    checks++;
    if (d_rdata != 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_back: d_rdata=%h want deadbeef", d_rdata);
    end

    // Simultaneous requests
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 0; d_addr = 32'h24;
    wait_done(40);

    // Reset in the middle of a store
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    d_req = 0;
    #1;
    checks++;
    if ({i_valid, d_valid, mem_req, mem_we, busy, i_stall, d_stall} != 7'b0 ||
        mem_addr != 0 || mem_wdata != 0 || i_rdata != 0 || d_rdata != 0) begin
      errors++;
      $display("FAIL reset_abort: outputs not zero busy=%0b mem_req=%0b mem_we=%0b",
               busy, mem_req, mem_we);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy || mem[8'h40] != 32'hDEADBEEF) begin
      errors++;
      $display("FAIL abort_nowrite: busy=%0b mem[0x100]=%h want 0/deadbeef",
               busy, mem[8'h40]);
    end

    // Flush: request dropped during the access
    n0 = i_done;
    i_req = 1; i_addr = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_req = 0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (i_done != n0 + 1 || busy) begin
      errors++;
      $display("FAIL flush: completions=%0d busy=%0b want 1/0", i_done - n0, busy);
    end
    i_seen = i_done;

    // MEM_LATENCY=1 instance with a continuous fetch request
    i_req1 = 1;
    c0 = cyc;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      eb = ((cyc - c0) % 3) != 0;
      ev = ((cyc - c0) % 3) == 2;
      checks++;
      if (busy1 != eb || i_valid1 != ev || (ev && i_rdata1 != ~32'h44)) begin
        errors++;
        $display("FAIL lat1 step %0d: busy=%0b/%0b i_valid=%0b/%0b rdata=%h",
                 cyc - c0, busy1, eb, i_valid1, ev, i_rdata1);
      end
    end
    @(posedge clk); #1;
    i_req1 = 0;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (i_done != i_seen) begin
        i_seen = i_done;
        i_req  = 1'($urandom_range(0, 1));
        i_addr = raddr();
      end else if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = raddr(); end
      end else if ($urandom_range(0, 31) == 0) begin
        i_req = 0;
      end
      if (d_done != d_seen) begin
        d_seen  = d_done;
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = raddr();
        d_wdata = $urandom();
      end else if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = raddr(); d_wdata = $urandom();
        end
      end else if ($urandom_range(0, 31) == 0) begin
        d_req = 0;
      end
      if ($urandom_range(0, 7) == 0) begin
        i_addr = raddr(); d_addr = raddr(); d_wdata = $urandom();
      end
    end
    wait_done(40);
    repeat (L + 4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain: %0d expected completions left, busy=%0b",
               exp_q.size(), busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
